// File: rtl/bec_key_serializer.sv
// rtl/bec_key_serializer.sv - scalar key store and MSB-first bit serializer for the binary-Edwards core
//
// Holds the KEY_W-bit scalar k, written as 32-bit words, and presents it one
// bit at a time on ki (MSB first), advancing on each next_key pulse.
// With SKIP_LZ=1 the leading zero bits are consumed internally first, so the
// core's first bit is the most significant set bit of k.
//
// Ports:
//   wb_clk_i   clock, rising-edge
//   wb_rst_i   asynchronous active-high reset
//   wr_en      key word write strobe
//   wr_addr    key word index (0..WORDS-1)
//   wr_data    key word data
//   start      begin serialising the loaded key
//   abort      return to IDLE from any state
//   next_key   current bit consumed, advance
//   ki         current key bit
//   key_valid  ki holds a valid bit
//   key_last   ki is bit 0
//   bit_idx    index of the bit on ki
//   busy       SCAN or SHIFT in progress
//   done       one-cycle end-of-run pulse
//   zero_key   sticky: last run found k == 0
//   wr_err     sticky: dropped write (busy or bad address)
module bec_key_serializer #(
    parameter int KEY_W   = 163,
    parameter int WORDS   = 6,
    parameter bit SKIP_LZ = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        start,
    input  logic        abort,
    input  logic        next_key,
    output logic        ki,
    output logic        key_valid,
    output logic        key_last,
    output logic [7:0]  bit_idx,
    output logic        busy,
    output logic        done,
    output logic        zero_key,
    output logic        wr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   r_shift;
    logic [7:0]         r_bit_idx;
    logic               r_done;
    logic               r_zero_key;
    logic               r_wr_err;

    logic               w_can_write;
    logic               w_addr_ok;
    logic               w_wr_ok;
    logic               w_wr_bad;

    assign w_can_write = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_addr_ok   = int'(wr_addr) < WORDS;
    assign w_wr_ok     = wr_en && w_can_write && w_addr_ok;
    assign w_wr_bad    = wr_en && !w_wr_ok;

    // Bit-wise word mapping: key bit i comes from word i/32, lane i%32.
    // Lanes beyond KEY_W in the top word simply have no destination.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_key <= '0;
        end else if (w_wr_ok) begin
            for (int i = 0; i < KEY_W; i++) begin
                if ((i / 32) == int'(wr_addr)) begin
                    r_key[i] <= wr_data[i % 32];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_done     <= 1'b0;
            r_zero_key <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_shift    <= r_key;
                            r_bit_idx  <= 8'(KEY_W - 1);
                            r_zero_key <= 1'b0;
                            r_wr_err   <= 1'b0;
                            r_state    <= SKIP_LZ ? S_SCAN : S_SHIFT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_SCAN: begin
                        if (r_shift[KEY_W-1]) begin
                            r_state <= S_SHIFT;
                        end else if (r_bit_idx == 8'd0) begin
                            r_state    <= S_DONE;
                            r_zero_key <= 1'b1;
                            r_done     <= 1'b1;
                        end else begin
                            r_shift   <= {r_shift[KEY_W-2:0], 1'b0};
                            r_bit_idx <= r_bit_idx - 8'd1;
                        end
                    end
                    S_SHIFT: begin
                        if (next_key) begin
                            if (r_bit_idx == 8'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_shift   <= {r_shift[KEY_W-2:0], 1'b0};
                                r_bit_idx <= r_bit_idx - 8'd1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // A dropped write in the same cycle as start still flags.
            if (w_wr_bad) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    // Decoded from registered state only, so reset clears them immediately.
    assign ki        = (r_state == S_SHIFT) && r_shift[KEY_W-1];
    assign key_valid = (r_state == S_SHIFT);
    assign key_last  = (r_state == S_SHIFT) && (r_bit_idx == 8'd0);
    assign busy      = (r_state == S_SCAN) || (r_state == S_SHIFT);
    assign bit_idx   = r_bit_idx;
    assign done      = r_done;
    assign zero_key  = r_zero_key;
    assign wr_err    = r_wr_err;

endmodule
